// File: rtl/board_top.sv
// board_top: PS/2 keyboard receiver and scancode decoder, 8-digit multiplexed
// seven-segment display and a 640x480@60 VGA solid-colour raster.
module board_top #(
  parameter int CLK_HZ      = 100_000_000,
  parameter int PS2_TIMEOUT = 10000,
  parameter int DIGIT_SHIFT = 14
) (
  input  logic        sys_clk_i,
  input  logic        reset_ni,
  input  logic [15:0] switch_i,
  input  logic        ps2_clk_i,
  input  logic        ps2_data_i,
  output logic        halt_o,
  output logic [7:0]  dsp_anode_o,
  output logic [7:0]  dsp_cathode_o,
  output logic [3:0]  vga_red_o,
  output logic [3:0]  vga_green_o,
  output logic [3:0]  vga_blue_o,
  output logic        vga_hsync_o,
  output logic        vga_vsync_o
);

  // Pixel clock enable divides the system clock down to 25 MHz (4 at 100 MHz).
  localparam int PIX_DIV = (CLK_HZ / 25_000_000 > 1) ? CLK_HZ / 25_000_000 : 1;
  localparam int PIX_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam int IDLE_W  = $clog2(PS2_TIMEOUT + 1);
  localparam int SCAN_W  = DIGIT_SHIFT + 3;

  localparam logic [9:0] H_VIS = 10'd640, H_SYNC_LO = 10'd656, H_SYNC_HI = 10'd751, H_LAST = 10'd799;
  localparam logic [9:0] V_VIS = 10'd480, V_SYNC_LO = 10'd490, V_SYNC_HI = 10'd491, V_LAST = 10'd524;

  // ---------------------------------------------------------------- sync
  logic [17:0] async_in;
  logic [17:0] sync_vec;
  logic [15:0] sw_s;
  logic        ps2_clk_s, ps2_data_s;

  assign async_in = {switch_i, ps2_clk_i, ps2_data_i};

  genvar gi;
  generate
    for (gi = 0; gi < 18; gi++) begin : g_sync
      logic meta_reg, sync_reg;
      // Two-flop synchronizer for one asynchronous input bit
      always_ff @(posedge sys_clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
          meta_reg <= 1'b0;
          sync_reg <= 1'b0;
        end else begin
          meta_reg <= async_in[gi];
          sync_reg <= meta_reg;
        end
      end
      assign sync_vec[gi] = sync_reg;
    end
  endgenerate

  assign sw_s       = sync_vec[17:2];
  assign ps2_clk_s  = sync_vec[1];
  assign ps2_data_s = sync_vec[0];

  // ---------------------------------------------------------------- PS/2 rx
  logic              ps2_clk_prev_reg;
  logic [3:0]        bit_cnt_reg;
  logic [9:0]        frame_reg;      // start, data[0..7], parity once full
  logic [IDLE_W-1:0] idle_cnt_reg;
  logic              byte_valid_reg;
  logic [7:0]        byte_data_reg;
  logic              halt_reg;
  logic              ps2_fall;

  assign ps2_fall = ps2_clk_prev_reg & ~ps2_clk_s;

  // Shift in one bit per PS/2 falling edge; validate the frame on the stop bit
  always_ff @(posedge sys_clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      ps2_clk_prev_reg <= 1'b0;
      bit_cnt_reg      <= 4'd0;
      frame_reg        <= 10'd0;
      idle_cnt_reg     <= '0;
      byte_valid_reg   <= 1'b0;
      byte_data_reg    <= 8'd0;
      halt_reg         <= 1'b0;
    end else begin
      ps2_clk_prev_reg <= ps2_clk_s;
      byte_valid_reg   <= 1'b0;
      if (ps2_fall) begin
        idle_cnt_reg <= '0;
        if (bit_cnt_reg == 4'd10) begin
          bit_cnt_reg <= 4'd0;
          // start low, stop high, odd parity over data+parity
          if (!frame_reg[0] && ps2_data_s && (^frame_reg[9:1])) begin
            byte_valid_reg <= 1'b1;
            byte_data_reg  <= frame_reg[8:1];
          end else begin
            halt_reg <= 1'b1;
          end
        end else begin
          frame_reg   <= {ps2_data_s, frame_reg[9:1]};
          bit_cnt_reg <= bit_cnt_reg + 4'd1;
        end
      end else if (bit_cnt_reg != 4'd0) begin
        // A stalled frame is silently abandoned, not flagged as an error
        if (idle_cnt_reg == IDLE_W'(PS2_TIMEOUT - 1)) begin
          bit_cnt_reg  <= 4'd0;
          idle_cnt_reg <= '0;
        end else begin
          idle_cnt_reg <= idle_cnt_reg + 1'b1;
        end
      end else begin
        idle_cnt_reg <= '0;
      end
    end
  end

  // ---------------------------------------------------------------- decoder
  logic       break_pend_reg, ext_pend_reg, key_down_reg;
  logic [7:0] last_code_reg, make_count_reg;

  // Track prefixes and turn plain codes into make/break events
  always_ff @(posedge sys_clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      break_pend_reg <= 1'b0;
      ext_pend_reg   <= 1'b0;
      key_down_reg   <= 1'b0;
      last_code_reg  <= 8'd0;
      make_count_reg <= 8'd0;
    end else if (byte_valid_reg) begin
      if (byte_data_reg == 8'hF0) begin
        break_pend_reg <= 1'b1;
      end else if (byte_data_reg == 8'hE0) begin
        ext_pend_reg <= 1'b1;
      end else begin
        if (!break_pend_reg) begin
          last_code_reg  <= byte_data_reg;
          key_down_reg   <= 1'b1;
          make_count_reg <= make_count_reg + 8'd1;
        end else if (byte_data_reg == last_code_reg) begin
          key_down_reg <= 1'b0;
        end
        // Prefix flags only live until the next plain code
        if (break_pend_reg || ext_pend_reg) begin
          break_pend_reg <= 1'b0;
          ext_pend_reg   <= 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------- display
  logic [SCAN_W-1:0] scan_cnt_reg;
  logic [2:0]        digit_idx;
  logic [3:0]        nibble;
  logic [7:0]        seg_pattern;
  logic [7:0]        anode_reg, cathode_reg;

  assign digit_idx = scan_cnt_reg[SCAN_W-1 -: 3];

  // Pick the hex nibble shown on the currently scanned digit
  always_comb begin
    nibble = 4'h0;
    case (digit_idx)
      3'd7: nibble = sw_s[15:12];
      3'd6: nibble = sw_s[11:8];
      3'd5: nibble = sw_s[7:4];
      3'd4: nibble = sw_s[3:0];
      3'd3: nibble = last_code_reg[7:4];
      3'd2: nibble = last_code_reg[3:0];
      3'd1: nibble = make_count_reg[7:4];
      default: nibble = make_count_reg[3:0];
    endcase
  end

  // Active-low seven-segment glyphs, decimal point off
  always_comb begin
    seg_pattern = 8'hFF;
    case (nibble)
      4'h0: seg_pattern = 8'hC0;  4'h1: seg_pattern = 8'hF9;
      4'h2: seg_pattern = 8'hA4;  4'h3: seg_pattern = 8'hB0;
      4'h4: seg_pattern = 8'h99;  4'h5: seg_pattern = 8'h92;
      4'h6: seg_pattern = 8'h82;  4'h7: seg_pattern = 8'hF8;
      4'h8: seg_pattern = 8'h80;  4'h9: seg_pattern = 8'h90;
      4'hA: seg_pattern = 8'h88;  4'hB: seg_pattern = 8'h83;
      4'hC: seg_pattern = 8'hC6;  4'hD: seg_pattern = 8'hA1;
      4'hE: seg_pattern = 8'h86;  default: seg_pattern = 8'h8E;
    endcase
  end

  // Register anode and cathode from the same index so they always agree
  always_ff @(posedge sys_clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      scan_cnt_reg <= '0;
      anode_reg    <= 8'hFF;
      cathode_reg  <= 8'hFF;
    end else begin
      scan_cnt_reg <= scan_cnt_reg + 1'b1;
      anode_reg    <= ~(8'd1 << digit_idx);
      cathode_reg  <= {seg_pattern[7] & ~((digit_idx == 3'd0) & key_down_reg), seg_pattern[6:0]};
    end
  end

  // ---------------------------------------------------------------- VGA
  logic [PIX_W-1:0] pix_cnt_reg;
  logic [9:0]       h_cnt_reg, v_cnt_reg;
  logic             hsync_reg, vsync_reg;
  logic [11:0]      rgb_reg;
  logic             pix_en;

  assign pix_en = (pix_cnt_reg == PIX_W'(PIX_DIV - 1));

  // Raster counters and registered sync/colour, updated once per pixel
  always_ff @(posedge sys_clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      pix_cnt_reg <= '0;
      h_cnt_reg   <= 10'd0;
      v_cnt_reg   <= 10'd0;
      hsync_reg   <= 1'b1;
      vsync_reg   <= 1'b1;
      rgb_reg     <= 12'd0;
    end else begin
      pix_cnt_reg <= pix_en ? '0 : pix_cnt_reg + 1'b1;
      if (pix_en) begin
        hsync_reg <= !((h_cnt_reg >= H_SYNC_LO) && (h_cnt_reg <= H_SYNC_HI));
        vsync_reg <= !((v_cnt_reg >= V_SYNC_LO) && (v_cnt_reg <= V_SYNC_HI));
        if ((h_cnt_reg < H_VIS) && (v_cnt_reg < V_VIS))
          rgb_reg <= sw_s[11:0] ^ {12{key_down_reg}};
        else
          rgb_reg <= 12'd0;
        if (h_cnt_reg == H_LAST) begin
          h_cnt_reg <= 10'd0;
          v_cnt_reg <= (v_cnt_reg == V_LAST) ? 10'd0 : v_cnt_reg + 10'd1;
        end else begin
          h_cnt_reg <= h_cnt_reg + 10'd1;
        end
      end
    end
  end

  assign halt_o        = halt_reg;
  assign dsp_anode_o   = anode_reg;
  assign dsp_cathode_o = cathode_reg;
  assign vga_red_o     = rgb_reg[11:8];
  assign vga_green_o   = rgb_reg[7:4];
  assign vga_blue_o    = rgb_reg[3:0];
  assign vga_hsync_o   = hsync_reg;
  assign vga_vsync_o   = vsync_reg;

endmodule

// File: tb/tb_board_top.sv
// tb_board_top: directed + randomized bench for board_top with a
// frame/scancode-level reference model.
module tb_board_top;
  localparam int DS = 2;     // fast digit scan: 4 cycles per digit
  localparam int TO = 100;   // PS/2 abort after 100 idle cycles

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] sw = 16'h9999;
  logic        ps2c = 1'b1, ps2d = 1'b1;
  logic        halt, hsync, vsync;
  logic [7:0]  anode, cathode;
  logic [3:0]  red, green, blue;

  always #5 clk = ~clk;

  board_top #(.CLK_HZ(100_000_000), .PS2_TIMEOUT(TO), .DIGIT_SHIFT(DS)) dut (
    .sys_clk_i(clk), .reset_ni(rst_n), .switch_i(sw),
    .ps2_clk_i(ps2c), .ps2_data_i(ps2d), .halt_o(halt),
    .dsp_anode_o(anode), .dsp_cathode_o(cathode),
    .vga_red_o(red), .vga_green_o(green), .vga_blue_o(blue),
    .vga_hsync_o(hsync), .vga_vsync_o(vsync)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] m_last = 8'd0, m_count = 8'd0;
  logic       m_key = 1'b0, m_brk = 1'b0, m_halt = 1'b0;

  logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  logic [7:0] seq4 [13] = '{8'h33, 8'h24, 8'h4B, 8'h4B, 8'h44, 8'h41, 8'h29,
                            8'h1D, 8'h44, 8'h2D, 8'h4B, 8'h23, 8'h5A};
  logic [7:0] pool [8] = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h33, 8'h34, 8'h4B, 8'h5A};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scancode rules applied to one accepted byte
  task automatic model_byte(input logic [7:0] b);
    if (b == 8'hF0) m_brk = 1'b1;
    else if (b != 8'hE0) begin
      if (!m_brk) begin
        m_last = b; m_key = 1'b1; m_count = m_count + 8'd1;
      end else if (b == m_last) m_key = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic ps2_bits(input logic [10:0] bits, input int nbits, input bit fast);
    for (int i = 0; i < nbits; i++) begin
      ps2d = bits[i];
      if (fast) begin #20 ps2c = 1'b0; #40 ps2c = 1'b1; #20; end
      else begin #30 ps2c = 1'b0; #100 ps2c = 1'b1; #70; end
    end
    ps2d = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit fast);
    logic par;
    par = ~(^b) ^ bad_par;
    @(negedge clk);
    ps2_bits({1'b1, par, b, 1'b0}, 11, fast);
    if (fast) #100; else #300;
    if (bad_par) m_halt = 1'b1;
    else model_byte(b);
  endtask

  task automatic check_display(input string tag);
    logic [7:0] exp_c [8];
    logic [7:0] exp_a;
    logic [3:0] nib;
    int n;
    for (int d = 0; d < 8; d++) begin
      if (d >= 4) nib = sw[4*(d-4) +: 4];
      else if (d >= 2) nib = m_last[4*(d-2) +: 4];
      else nib = m_count[4*d +: 4];
      exp_c[d] = hex_tab[nib];
    end
    if (m_key) exp_c[0][7] = 1'b0;
    repeat (4) @(negedge clk);
    n = 0;
    while (anode !== 8'hFE && n < 64) begin @(negedge clk); n++; end
    chk({tag, " scan-start"}, {24'd0, anode}, 32'hFE);
    for (int d = 0; d < 8; d++) begin
      exp_a = ~(8'h01 << d);
      chk($sformatf("%s digit%0d an/cat", tag, d), {16'd0, anode, cathode}, {16'd0, exp_a, exp_c[d]});
      repeat (1 << DS) @(negedge clk);
    end
  endtask

  task automatic wait_hs(input logic lvl, output bit ok);
    int n = 0;
    while (hsync !== lvl && n < 4000) begin @(negedge clk); n++; end
    ok = (hsync === lvl);
  endtask

  task automatic check_rgb(input string tag);
    bit ok1, ok2;
    logic [11:0] exp_rgb;
    exp_rgb = sw[11:0] ^ {12{m_key}};
    wait_hs(1'b0, ok1);
    wait_hs(1'b1, ok2);
    repeat (300) @(negedge clk);
    chk({tag, " rgb visible"}, {19'd0, ok1, red, green, blue}, {19'd0, ok2, exp_rgb});
    wait_hs(1'b0, ok1);
    repeat (10) @(negedge clk);
    chk({tag, " rgb blank/vsync"}, {18'd0, ok1, vsync, red, green, blue}, {18'd0, 1'b1, 1'b1, 12'd0});
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("halt in reset", {31'd0, halt}, 32'd0);
    m_last = 8'd0; m_count = 8'd0; m_key = 1'b0; m_brk = 1'b0; m_halt = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    bit ok1, ok2;
    int low, per, guard;
    logic [7:0] code;
    int r;

    // Step 1: reset state
    repeat (5) @(negedge clk);
    chk("reset halt", {31'd0, halt}, 32'd0);
    chk("reset an/cat", {16'd0, anode, cathode}, 32'hFFFF);
    chk("reset rgb/sync", {18'd0, hsync, vsync, red, green, blue}, {18'd0, 2'b11, 12'd0});
    rst_n = 1'b1;
    check_display("after reset");

    // Step 2: make 0x33
    send_byte(8'h33, 1'b0, 1'b0);
    check_display("make 33");
    chk("make 33 halt", {31'd0, halt}, {31'd0, m_halt});
    check_rgb("make 33");

    // Step 3: break 0x33
    send_byte(8'hF0, 1'b0, 1'b0);
    send_byte(8'h33, 1'b0, 1'b0);
    check_display("break 33");
    check_rgb("break 33");

    // Step 4: full typing sequence from reset
    pulse_reset();
    for (int i = 0; i < 13; i++) begin
      send_byte(seq4[i], 1'b0, 1'b0);
      send_byte(8'hF0, 1'b0, 1'b0);
      send_byte(seq4[i], 1'b0, 1'b0);
    end
    check_display("sequence");
    chk("sequence halt", {31'd0, halt}, 32'd0);

    // Step 6: horizontal timing
    wait_hs(1'b1, ok1);
    wait_hs(1'b0, ok2);
    low = 0;
    while (hsync === 1'b0 && low < 5000) begin @(negedge clk); low++; end
    per = low;
    while (hsync === 1'b1 && per < 10000) begin @(negedge clk); per++; end
    chk("hsync low cycles", low, 384);
    chk("hsync period cycles", per, 3200);
    chk("hsync found/vsync high", {29'd0, ok1, ok2, vsync}, 32'd7);

    // Stalled partial frame is dropped without error
    @(negedge clk);
    ps2_bits(11'b000_0000_1010, 5, 1'b0);
    #3000;
    send_byte(8'h1C, 1'b0, 1'b0);
    check_display("after timeout");
    chk("timeout halt", {31'd0, halt}, 32'd0);

    // Randomized keystrokes and switch settings
    for (int it = 0; it < 16; it++) begin
      if ($urandom_range(0, 3) == 0) sw = 16'($urandom);
      code = pool[$urandom_range(0, 7)];
      r = $urandom_range(0, 9);
      if (r < 3) send_byte(8'hF0, 1'b0, 1'b0);
      else if (r == 3) send_byte(8'hE0, 1'b0, 1'b0);
      else if (r == 4) begin
        send_byte(8'hE0, 1'b0, 1'b0);
        send_byte(8'hF0, 1'b0, 1'b0);
      end
      send_byte(code, 1'b0, 1'b0);
      check_display($sformatf("random %0d", it));
      if (it % 8 == 7) check_rgb($sformatf("random %0d", it));
    end
    chk("random halt", {31'd0, halt}, {31'd0, m_halt});

    // make_count wraps 255 -> 0
    guard = 0;
    while (m_count != 8'h00 && guard < 300) begin
      send_byte(8'h15, 1'b0, 1'b1);
      if (m_count == 8'hFF) check_display("count ff");
      guard++;
    end
    check_display("count wrap");

    // Step 5: parity error is sticky, later frames still decode
    send_byte(8'h1A, 1'b1, 1'b0);
    chk("bad parity halt", {31'd0, halt}, {31'd0, m_halt});
    check_display("bad parity");
    send_byte(8'h2C, 1'b0, 1'b0);
    check_display("after error");
    chk("halt sticky", {31'd0, halt}, 32'd1);
    pulse_reset();
    chk("halt cleared", {31'd0, halt}, 32'd0);
    check_display("final reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
